// File: rtl/pll_freq_monitor_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous square wave, followed by a
// rising-edge detector that pulses for one clk cycle per input rise.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/pll_freq_monitor.sv
// Counts rising edges of a divided PLL clock over a fixed clk window, flags
// each count against a tolerance band and qualifies lock after a run of good windows.
module pll_freq_monitor #(
    parameter int WINDOW_CYCLES = 27000,
    parameter int CNT_W         = 16,
    parameter int EXPECT_MIN    = 970,
    parameter int EXPECT_MAX    = 1000,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             meas_in,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             meas_ok,
    output logic             locked
);

    localparam int TIMER_W = $clog2(WINDOW_CYCLES);
    localparam int GR_W    = $clog2(LOCK_WINDOWS + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   EXP_MIN_C   = CNT_W'(EXPECT_MIN);
    localparam logic [CNT_W-1:0]   EXP_MAX_C   = CNT_W'(EXPECT_MAX);
    localparam logic [GR_W-1:0]    LOCK_TARGET = GR_W'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        UNLOCKED   = 2'd0,
        QUALIFYING = 2'd1,
        LOCKED     = 2'd2
    } lock_state_t;

    logic               edge_now;
    logic               terminal;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   edge_sum;
    logic               window_good;
    lock_state_t        state;
    lock_state_t        state_next;
    logic [GR_W-1:0]    good_run;
    logic [GR_W-1:0]    good_run_next;

    // Synchronizer is cleared by rst only; restart leaves it running.
    sync_edge_detect u_sync (
        .clk   (clk),
        .rst   (rst),
        .level (meas_in),
        .rise  (edge_now)
    );

    assign terminal    = (timer == TIMER_LAST);
    assign edge_sum    = (edge_now && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign window_good = (edge_sum >= EXP_MIN_C) && (edge_sum <= EXP_MAX_C);

    // The terminal cycle folds its own edge into the result, so no edge is lost.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            timer      <= '0;
            edge_cnt   <= '0;
            meas_count <= '0;
            meas_ok    <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= terminal;
            if (terminal) begin
                timer      <= '0;
                edge_cnt   <= '0;
                meas_count <= edge_sum;
                meas_ok    <= window_good;
            end else begin
                timer    <= timer + TIMER_W'(1);
                edge_cnt <= edge_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state    <= UNLOCKED;
            good_run <= '0;
        end else begin
            state    <= state_next;
            good_run <= good_run_next;
        end
    end

    always_comb begin
        state_next    = state;
        good_run_next = good_run;
        if (terminal) begin
            case (state)
                UNLOCKED: begin
                    if (window_good) begin
                        good_run_next = GR_W'(1);
                        state_next    = (LOCK_WINDOWS == 1) ? LOCKED : QUALIFYING;
                    end
                end
                QUALIFYING: begin
                    if (window_good) begin
                        good_run_next = good_run + GR_W'(1);
                        if ((good_run + GR_W'(1)) == LOCK_TARGET) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        good_run_next = '0;
                        state_next    = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!window_good) begin
                        good_run_next = '0;
                        state_next    = UNLOCKED;
                    end
                end
                default: begin
                    good_run_next = '0;
                    state_next    = UNLOCKED;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Randomized window-level stimulus for pll_freq_monitor, checked by a scoreboard
// fed from an edge-counting reference model; a CNT_W=6 instance covers saturation.
module tb_pll_freq_monitor;

    localparam int W     = 1000;
    localparam int E_MIN = 48;
    localparam int E_MAX = 52;
    localparam int LOCKN = 4;

    logic        clk;
    logic        rst;
    logic        restart;
    logic        meas_in;
    logic [15:0] meas_count;
    logic        meas_valid;
    logic        meas_ok;
    logic        locked;

    logic        meas_in_s;
    logic [5:0]  meas_count_s;
    logic        meas_valid_s;
    logic        meas_ok_s;
    logic        locked_s;

    logic [17:0] exp_q[$];   // {locked, ok, count}
    int          n_cmp = 0;
    int          n_err = 0;

    // reference-model stimulus state
    int          per = 20;
    int          hi = 10;
    int          ph = 0;
    bit          mode_stuck = 0;
    bit          stuck_lvl = 0;
    bit          last_in = 0;
    int          win_edges = 0;
    int          run = 0;

    pll_freq_monitor #(
        .WINDOW_CYCLES(W), .CNT_W(16), .EXPECT_MIN(E_MIN), .EXPECT_MAX(E_MAX), .LOCK_WINDOWS(LOCKN)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .meas_in(meas_in),
        .meas_count(meas_count), .meas_valid(meas_valid), .meas_ok(meas_ok), .locked(locked)
    );

    pll_freq_monitor #(
        .WINDOW_CYCLES(W), .CNT_W(6), .EXPECT_MIN(E_MIN), .EXPECT_MAX(E_MAX), .LOCK_WINDOWS(LOCKN)
    ) dut_sat (
        .clk(clk), .rst(rst), .restart(restart), .meas_in(meas_in_s),
        .meas_count(meas_count_s), .meas_valid(meas_valid_s), .meas_ok(meas_ok_s), .locked(locked_s)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input bit pass, input int act, input int expv);
        n_cmp++;
        if (!pass) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // ---------------- driver side ----------------
    function automatic logic cur_level();
        if (mode_stuck) return stuck_lvl;
        return ((ph % per) < hi);
    endfunction

    task automatic push_window();
        bit ok;
        ok  = (win_edges >= E_MIN) && (win_edges <= E_MAX);
        run = ok ? ((run < LOCKN) ? run + 1 : LOCKN) : 0;
        exp_q.push_back({(run >= LOCKN), ok, 16'(win_edges)});
        win_edges = 0;
    endtask

    task automatic drive_cycles(input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            meas_in = cur_level();
            if (meas_in && !last_in) win_edges++;
            last_in = meas_in;
            ph++;
            if (push && i == n - 1) push_window();
            @(negedge clk);
        end
    endtask

    task automatic set_pattern(input int p, input int h);
        mode_stuck = 0;
        per = p;
        hi  = h;
        ph  = $urandom_range(0, p - 1);
    endtask

    task automatic set_stuck(input bit lvl);
        mode_stuck = 1;
        stuck_lvl  = lvl;
    endtask

    task automatic do_reset(input bit with_restart);
        rst     = 1'b1;
        restart = with_restart;
        repeat (5) begin
            meas_in = ~meas_in;
            @(negedge clk);
        end
        rst       = 1'b0;
        restart   = 1'b0;
        last_in   = 1'b0;
        win_edges = 0;
        run       = 0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart   = 1'b0;
        win_edges = 0;
        run       = 0;
    endtask

    task automatic windows(input int n);
        for (int k = 0; k < n; k++) drive_cycles(W, 1'b1);
    endtask

    // saturation instance: period-4 square wave, 250 rises per window
    initial begin
        meas_in_s = 1'b0;
        forever begin
            @(negedge clk);
            meas_in_s = ((($time / 10) % 4) < 2);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   since;
        bit   lock_cur;
        bit   exp_v;
        int   a;
        int   e;
        logic [17:0] ent;
        since    = 0;
        lock_cur = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || restart) begin
                since    = 0;
                lock_cur = 0;
                check("clear_outputs", {meas_valid, meas_ok, locked, meas_count} == 19'd0,
                      int'({meas_valid, meas_ok, locked, meas_count}), 0);
                check("clear_outputs_sat", {meas_valid_s, meas_ok_s, locked_s, meas_count_s} == 9'd0,
                      int'({meas_valid_s, meas_ok_s, locked_s, meas_count_s}), 0);
            end else begin
                since++;
                exp_v = (since % W) == 0;
                if (exp_v || meas_valid)
                    check("valid_timing", meas_valid == exp_v, int'(meas_valid), int'(exp_v));
                if (exp_v || meas_valid_s)
                    check("valid_timing_sat", meas_valid_s == exp_v, int'(meas_valid_s), int'(exp_v));
                if (meas_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1'b0, exp_q.size(), 1);
                    end else begin
                        ent = exp_q.pop_front();
                        a   = int'(meas_count);
                        e   = int'(ent[15:0]);
                        check("meas_count", (a >= e - 1) && (a <= e + 1), a, e);
                        check("meas_ok", meas_ok == ent[16], int'(meas_ok), int'(ent[16]));
                        lock_cur = ent[17];
                    end
                end
                check("locked", locked == lock_cur, int'(locked), int'(lock_cur));
                if (meas_valid_s) begin
                    check("sat_count", meas_count_s == 6'd63, int'(meas_count_s), 63);
                    check("sat_ok", meas_ok_s == 1'b0, int'(meas_ok_s), 0);
                end
                check("sat_locked", locked_s == 1'b0, int'(locked_s), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst     = 1'b1;
        restart = 1'b0;
        meas_in = 1'b0;
        @(negedge clk);

        // reset with toggling input, then lock on period 20
        do_reset(1'b0);
        set_pattern(20, 10);
        windows(5);

        // loss of lock with period 10, then relock
        set_pattern(10, 5);
        windows(1);
        set_pattern(20, 10);
        windows(4);

        // stuck input low, then high
        set_stuck(1'b0);
        windows(2);
        set_stuck(1'b1);
        windows(2);

        // randomized window patterns
        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: set_pattern(20, $urandom_range(5, 15));
                5:             set_pattern(10, 5);
                6:             set_pattern(25, 12);
                7:             set_pattern(16, 8);
                8:             set_stuck(1'b0);
                default:       set_stuck(1'b1);
            endcase
            windows(1);
        end

        // restart mid-window while locked
        set_pattern(20, 10);
        windows(4);
        drive_cycles(500, 1'b0);
        do_restart();
        check("restart_clears_locked", locked == 1'b0, int'(locked), 0);
        check("restart_clears_count", meas_count == 16'd0, int'(meas_count), 0);
        windows(2);

        // restart on the terminal cycle: that window yields no result
        drive_cycles(W - 1, 1'b0);
        do_restart();
        windows(1);

        // rst together with restart
        drive_cycles(300, 1'b0);
        do_reset(1'b1);
        check("reset_clears_ok", meas_ok == 1'b0, int'(meas_ok), 0);
        set_pattern(20, 10);
        windows(1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: simulation exceeded time budget, got %0t, expected below 5000000", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_freq_monitor.md
# pll_freq_monitor

Checks a Gowin rPLL output against the 27 MHz board clock on the Tang Nano 9K HDMI board. A divided-down copy of the PLL output, produced in the PLL domain, arrives asynchronously as a square wave. The block counts its rising edges over a fixed window of `clk` cycles, reports the count, and qualifies it against a tolerance band. It drives a `locked` flag that HDMI/TMDS logic uses to hold off video until the fast clock is proven stable.

## Interface
- `WINDOW_CYCLES`, 27000: measurement window length in `clk` cycles (1 ms at 27 MHz); must be ≥ 4.
- `CNT_W`, 16: width of the edge counter and `meas_count`.
- `EXPECT_MIN`, 970: lowest count accepted as good (inclusive).
- `EXPECT_MAX`, 1000: highest count accepted as good (inclusive). The nominal value is 984 for a 252 MHz PLL output divided by 256.
- `LOCK_WINDOWS`, 4: number of consecutive good windows required to assert `locked`.
- `clk`, in, 1: 27 MHz board clock. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `restart`, in, 1: synchronous one-cycle request to restart measurement, for example after the PLL is reset.
- `meas_in`, in, 1: divided PLL clock, asynchronous to `clk`; its frequency must be below `clk`/4.
- `meas_count`, out, CNT_W: edge count from the last completed window.
- `meas_valid`, out, 1: one-cycle pulse when `meas_count`/`meas_ok` update.
- `meas_ok`, out, 1: last count lies within [EXPECT_MIN, EXPECT_MAX].
- `locked`, out, 1: frequency qualified.

## Operation
- **Synchronizer.** Two flops, reset to 0, feed a third "previous" flop, also reset to 0. `edge_now` = sync2 & ~prev.
- **Window timer.** Counts 0..WINDOW_CYCLES-1 and wraps. The terminal cycle is timer == WINDOW_CYCLES-1.
- **Edge counter, non-terminal cycles.** The counter increments on `edge_now` and saturates at 2^CNT_W-1; it never wraps.
- **Edge counter, terminal cycle.**
  - Register `meas_count` ← sat(edge_cnt + edge_now).
  - `meas_ok` ← (EXPECT_MIN ≤ that value ≤ EXPECT_MAX).
  - `meas_valid` ← 1.
  - `edge_cnt` ← 0.
- **No dead cycle.** Every edge is counted in exactly one window.
- **Lock FSM.** A `good_run` counter (0..LOCK_WINDOWS, saturating) is evaluated only on terminal cycles.
  - UNLOCKED (reset state): a good window sets good_run=1 and moves to QUALIFYING, or goes directly to LOCKED if LOCK_WINDOWS==1. A bad window stays in UNLOCKED.
  - QUALIFYING: a good window increments good_run, and the FSM moves to LOCKED when good_run reaches LOCK_WINDOWS. A bad window clears good_run and returns to UNLOCKED.
  - LOCKED: a good window stays in LOCKED. A bad window clears good_run and moves to UNLOCKED.
  - `locked` is 1 only in LOCKED.
- **Restart and reset.**
  - `restart` clears timer, edge_cnt, good_run and the FSM (to UNLOCKED), and clears `meas_count`, `meas_ok` and `meas_valid`. It does not clear the synchronizer flops.
  - `rst` clears everything, including the synchronizer.
  - `rst` has priority over `restart`.
  - `restart` on a terminal cycle wins, and no `meas_valid` is produced for that window.

## Timing
- **Reset values.** All outputs are 0 on the cycle after `rst` is sampled high.
- **Input latency.** A rising edge on `meas_in` affects `edge_now` 3 `clk` cycles later. Edges within 3 cycles of a window boundary may land in either window, so the accepted band must allow ±1.
- **Output timing.** Outputs are registered and change on the clock following the terminal cycle.
  - Let cycle 0 be the first cycle after `rst`/`restart` is released.
  - The first `meas_valid` appears in cycle WINDOW_CYCLES.
  - Each subsequent pulse follows WINDOW_CYCLES cycles later.
  - `meas_valid` is never high for two consecutive cycles.
- **Lock timing.** `locked` rises in the same cycle as the LOCK_WINDOWS-th consecutive good `meas_valid`. It falls in the same cycle as the first bad `meas_valid`.
- **Holding.** `meas_count` and `meas_ok` hold between pulses.

## Structure
- No package; all constants are module parameters. The FSM state type is local to the module.
- One natural sub-module, `sync_edge_detect`: the 2-flop synchronizer plus rising-edge detector, with `rst` input and `edge` output. This block reuses it.

## Test plan
Benches run with WINDOW_CYCLES=1000, EXPECT_MIN=48, EXPECT_MAX=52, LOCK_WINDOWS=4 unless noted.
1. Reset: hold `rst` for 5 cycles with `meas_in` toggling → all outputs 0 during reset and the cycle after; first `meas_valid` at cycle 1000.
2. Lock: drive `meas_in` with period 20 `clk` (10 high / 10 low) → `meas_count` = 50 (±1) each window, `meas_ok`=1, `locked` rises with the 4th `meas_valid` and not before.
3. Loss of lock: once locked, change the period to 10 → the next full window gives `meas_count`=100 and `meas_ok`=0, and `locked` falls in that same `meas_valid` cycle. Restoring period 20 relocks after 4 good windows.
4. Stuck input: hold `meas_in` at 0, then at 1 → `meas_count`=0, `meas_ok`=0, `locked` stays 0.
5. Saturation: set CNT_W=6 and period 4 (250 edges) → `meas_count`=63 and `meas_ok`=0.
6. Restart/reset mid-run:
   - `restart` at cycle 500 while locked → `locked`, `meas_count` and `meas_ok` drop next cycle; next `meas_valid` 1000 cycles after release.
   - `restart` on a terminal cycle → no `meas_valid` for that window.
   - `rst` together with `restart` → reset behaviour.
